// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache fill FSM
// and the D-cache. Reads are 8-word line-fill bursts, writes are single-word
// write-throughs. Ties alternate between the two sides; a grant is held for
// the whole transaction.
module mem_arbiter #(
    parameter int MEM_LAT   = 4,
    parameter int BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_rvalid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic        d_rvalid,
    output logic        d_done,
    output logic [15:0] rdata,
    output logic [2:0]  rword,
    output logic        busy,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid
);

    // The word index field is 3 bits wide, so only 8-word lines are supported.
    if (MEM_LAT < 1 || BURST_LEN != 8) begin : g_param_check
        $error("mem_arbiter: unsupported MEM_LAT/BURST_LEN");
    end

    localparam logic [3:0] BURST_CNT = 4'(BURST_LEN);
    localparam logic [2:0] LAST_WORD = 3'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_issue_cnt;
    logic [2:0]  r_recv_cnt;
    logic        r_owner_d;     // 1: D-side owns the current transaction
    logic        r_last_d;      // 1: D-side owned the previous transaction
    logic [11:0] r_base;
    logic        r_i_grant;
    logic        r_d_grant;
    logic        r_mem_enable;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;

    logic        w_rvalid;
    logic        w_last;
    logic        w_grant_d;
    logic [11:0] w_new_base;
    logic        w_unused;

    // Line offset bits of the I-side address are never needed.
    assign w_unused = ^i_addr[3:0];

    // Returned data is only meaningful while a burst is being received.
    assign w_rvalid   = (r_state == StRead) && mem_data_valid;
    assign w_last     = w_rvalid && (r_recv_cnt == LAST_WORD);
    // D wins when alone, or on a tie when I owned the previous transaction.
    assign w_grant_d  = d_req && (!i_req || !r_last_d);
    assign w_new_base = w_grant_d ? d_addr[15:4] : i_addr[15:4];

    assign i_grant    = r_i_grant;
    assign d_grant    = r_d_grant;
    assign i_rvalid   = w_rvalid && !r_owner_d;
    assign d_rvalid   = w_rvalid && r_owner_d;
    assign i_done     = w_last && !r_owner_d;
    assign d_done     = (w_last && r_owner_d) || (r_state == StWrite);
    assign rdata      = w_rvalid ? mem_rdata : 16'h0000;
    assign rword      = w_rvalid ? r_recv_cnt : 3'd0;
    assign busy       = (r_state != StIdle);
    assign mem_enable = r_mem_enable;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    // Arbitration FSM; memory command outputs are registered one cycle ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_issue_cnt  <= 4'd0;
            r_recv_cnt   <= 3'd0;
            r_owner_d    <= 1'b0;
            r_last_d     <= 1'b0;
            r_base       <= 12'h000;
            r_i_grant    <= 1'b0;
            r_d_grant    <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_mem_wdata  <= 16'h0000;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req || d_req) begin
                        r_owner_d    <= w_grant_d;
                        r_last_d     <= w_grant_d;
                        r_i_grant    <= !w_grant_d;
                        r_d_grant    <= w_grant_d;
                        r_mem_enable <= 1'b1;
                        if (w_grant_d && d_wr) begin
                            r_state     <= StWrite;
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                        end else begin
                            // Word 0 goes out in the first READ cycle.
                            r_state     <= StRead;
                            r_mem_wr    <= 1'b0;
                            r_base      <= w_new_base;
                            r_mem_addr  <= {w_new_base, 3'd0, 1'b0};
                            r_issue_cnt <= 4'd1;
                            r_recv_cnt  <= 3'd0;
                        end
                    end
                end
                StRead: begin
                    if (r_issue_cnt < BURST_CNT) begin
                        r_mem_enable <= 1'b1;
                        r_mem_addr   <= {r_base, r_issue_cnt[2:0], 1'b0};
                        r_issue_cnt  <= r_issue_cnt + 4'd1;
                    end else begin
                        r_mem_enable <= 1'b0;
                    end
                    if (w_rvalid) begin
                        if (r_recv_cnt == LAST_WORD) begin
                            r_state      <= StIdle;
                            r_issue_cnt  <= 4'd0;
                            r_recv_cnt   <= 3'd0;
                            r_i_grant    <= 1'b0;
                            r_d_grant    <= 1'b0;
                            r_mem_enable <= 1'b0;
                        end else begin
                            r_recv_cnt <= r_recv_cnt + 3'd1;
                        end
                    end
                end
                StWrite: begin
                    r_state      <= StIdle;
                    r_i_grant    <= 1'b0;
                    r_d_grant    <= 1'b0;
                    r_mem_enable <= 1'b0;
                    r_mem_wr     <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified main memory (multi-cycle, pipelined memory4c-style: enable/wr/addr/data_in, data_out with data_valid) between two requesters: the I-cache fill FSM and the D-cache.
- Each read grant is an 8-word line-fill burst. Each write grant is a single-word D-cache write-through.
- Fair two-way arbitration. Holds the grant for a whole transaction.
- Exports busy so the pipeline can stall the PC and the MEM stage.

Parameters:
- MEM_LAT, 4, cycles from a mem_enable read issue to its mem_data_valid.
- BURST_LEN, 8, words per cache line. The 16-byte line makes the word index 3 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-side line-fill request; held until i_done
- i_addr  in  16  I-side miss address; [15:4] is the line base
- i_grant  out  1  I-side owns memory
- i_rvalid  out  1  rdata/rword valid for the I-side
- i_done  out  1  one-cycle pulse on the final I-side word
- d_req  in  1  D-side request; held until d_done
- d_wr  in  1  1 = single-word write, 0 = line fill
- d_addr  in  16  D-side address; full word address for writes, [15:4] for fills
- d_wdata  in  16  D-side write data
- d_grant  out  1  D-side owns memory
- d_rvalid  out  1  rdata/rword valid for the D-side
- d_done  out  1  one-cycle completion pulse for the D-side
- rdata  out  16  returned word (shared by both sides)
- rword  out  3  word index of rdata within the line
- busy  out  1  state != IDLE
- mem_enable  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  memory read data valid

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; issue_cnt=0, recv_cnt=0, last_owner=I.
  - All outputs 0, including mem_addr and mem_wdata.
  - Reset mid-transaction abandons it; no done pulse is produced.
- States: IDLE, READ, WRITE.
- IDLE:
  - If only one side requests, grant it.
  - If both request, grant the side that is not last_owner. After reset the D-side wins the first tie.
  - On grant: latch owner, base address, wr and wdata. Go to READ (i_req, or d_req with d_wr=0) or WRITE (d_req with d_wr=1). Set last_owner=owner.
  - A request arriving in the same cycle a done pulse fires is evaluated in the following IDLE cycle, so there is at least one IDLE cycle between transactions.
- Grant timing:
  - i_grant/d_grant are registered.
  - Asserted from the first READ/WRITE cycle through the done cycle inclusive.
  - Exactly one grant is high at a time, or none.
- READ issue:
  - While issue_cnt < BURST_LEN: mem_enable=1, mem_wr=0, mem_addr={base[15:4], issue_cnt, 1'b0}; issue_cnt increments.
  - mem_enable=0 after 8 issue cycles.
- READ receive:
  - Each mem_data_valid forwards mem_rdata on rdata, with rword=recv_cnt and the owner's rvalid=1 in the same cycle (combinational pass-through).
  - recv_cnt then increments.
  - On the valid with recv_cnt=7, the owner's done pulses, counters clear and the next state is IDLE.
- WRITE:
  - One cycle: mem_enable=1, mem_wr=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata.
  - d_done=1 in that cycle, then IDLE.
- Valid filtering: mem_data_valid outside READ, or after 8 words have been received, is ignored (no rvalid).
- Request drop: a requester dropping req mid-transaction does not abort it; the burst completes and done still pulses.
- Outputs when inactive: mem_addr and mem_wdata hold their last value when mem_enable=0. rdata and rword are don't-care when both rvalids are 0.
- Latency:
  - Read: first rvalid at issue+MEM_LAT; done at first issue + MEM_LAT + 7 (11 cycles with the default).
  - Write: done in the first WRITE cycle.

Test Plan:
- I-fill alone, i_addr=0x1236, MEM_LAT=4:
  - mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles.
  - i_rvalid with rword 0..7 starting 4 cycles after the first issue.
  - i_done on the 8th word, 11 cycles after the first issue; d_grant stays 0.
- Simultaneous i_req and d_req (d_wr=0) right after reset:
  - D served first.
  - I granted on the second cycle after d_done, i.e. after one IDLE cycle.
  - On the next tie I and D alternate.
- D write-through, d_addr=0x4002, d_wdata=0xBEEF:
  - One cycle of mem_enable=1, mem_wr=1, mem_addr=0x4002, mem_wdata=0xBEEF.
  - d_done in the same cycle; busy=0 on the next cycle.
- d_req asserted mid I-burst:
  - I burst finishes all 8 words without interruption.
  - D granted afterwards; its read addresses never interleave with the I-side addresses.
- rst_n pulled low at the 3rd received word of a fill:
  - Outputs go to 0 immediately (async).
  - No i_done.
  - After release, a new request restarts at rword 0.
- Stray mem_data_valid while IDLE or during WRITE:
  - No rvalid and no done.
  - State unchanged.
